// File: rtl/rotator_arbiter.sv
// Round-robin arbiter in front of one shared right-rotate barrel datapath with a registered result stage.
// Optional burst locking is compiled in with `define ROTATOR_ARB_LOCK_EN.
module rotator_arbiter #(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned SHIFTBITS_PER_STEP = 1,
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned MAX_BURST          = 4,
  localparam int unsigned ROTW = $clog2(WIDTH / SHIFTBITS_PER_STEP),
  localparam int unsigned IDW  = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ROTW-1:0] req_rot,
  input  logic [NUM_REQ-1:0]      req_lock,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDW-1:0]          out_id,
  input  logic                    out_ready
);

  localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic             accept;
  logic             found;
  logic             grant_en;
  logic             lock_hit;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_gnt;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   next_ptr;
  int unsigned      idx;
  logic [WIDTH-1:0] sel_data;
  logic [ROTW-1:0]  sel_rot;
  logic [ROTW-1:0]  rot_left;
  logic [WIDTH-1:0] rot_data;

  assign accept = !out_valid || out_ready;

  // Circular search for the first valid requester starting at rr_ptr
  always_comb begin
    found  = 1'b0;
    rr_gnt = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found  = 1'b1;
        rr_gnt = IDW'(idx);
      end
    end
  end

`ifdef ROTATOR_ARB_LOCK_EN
  logic [BCW-1:0] burst_cnt;
  logic [IDW-1:0] last_id;
  logic           locked;

  assign lock_hit = locked && req_valid[last_id] && (burst_cnt < BCW'(MAX_BURST - 1));
  assign gnt_id   = lock_hit ? last_id : rr_gnt;

  // Burst tracking: a locked re-grant bypasses the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      last_id   <= '0;
      locked    <= 1'b0;
    end else if (grant_en) begin
      last_id   <= gnt_id;
      locked    <= req_lock[gnt_id];
      burst_cnt <= lock_hit ? burst_cnt + BCW'(1) : '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = (^req_lock) ^ (BCW == 0);
  assign lock_hit    = 1'b0;
  assign gnt_id      = rr_gnt;
`endif

  assign grant_en  = rst_n && accept && found;
  assign req_ready = grant_en ? (NUM_REQ'(1) << gnt_id) : '0;
  assign next_ptr  = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);

  // Operand select for the granted requester
  always_comb begin
    sel_data = '0;
    sel_rot  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_rot  = req_rot[i*ROTW +: ROTW];
      end
    end
  end

  // Logarithmic barrel: stage k rotates right by SHIFTBITS_PER_STEP<<k bits
  always_comb begin
    rot_data = sel_data;
    rot_left = sel_rot;
    for (int unsigned k = 0; k < ROTW; k++) begin
      if (rot_left[0]) begin
        rot_data = (rot_data >> (SHIFTBITS_PER_STEP << k)) |
                   (rot_data << (WIDTH - (SHIFTBITS_PER_STEP << k)));
      end
      rot_left = rot_left >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= rot_data;
        out_id    <= gnt_id;
        if (!lock_hit) rr_ptr <= next_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotator_arbiter.sv
// Directed bench for rotator_arbiter: vector table plus reset, rotate-granularity and lock sequences.
module tb_rotator_arbiter;

  typedef struct packed {
    logic [3:0]       valid;
    logic             oready;
    logic [3:0][31:0] data;
    logic [3:0][4:0]  rot;
    logic [3:0]       exp_ready;
    logic             exp_valid;
    logic [31:0]      exp_data;
    logic [1:0]       exp_id;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]       req_valid = '0;
  logic [3:0][31:0] req_data = '0;
  logic [3:0][4:0]  req_rot = '0;
  logic [3:0]       req_lock = '0;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [1:0]       out_id;
  logic             out_ready = 1'b0;

  logic [3:0]       b_valid = '0;
  logic [3:0][31:0] b_data = '0;
  logic [3:0][1:0]  b_rot = '0;
  logic [3:0]       b_lock = '0;
  logic [3:0]       b_ready;
  logic             b_out_valid;
  logic [31:0]      b_out_data;
  logic [1:0]       b_out_id;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rotator_arbiter #(.WIDTH(32), .SHIFTBITS_PER_STEP(1), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_rot(req_rot),
    .req_lock(req_lock), .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready));

  rotator_arbiter #(.WIDTH(32), .SHIFTBITS_PER_STEP(8), .NUM_REQ(4), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data), .req_rot(b_rot),
    .req_lock(b_lock), .req_ready(b_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_id(b_out_id), .out_ready(1'b1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0][31:0] d,
                              input logic [3:0][4:0] rt, input logic [3:0] er, input logic ev,
                              input logic [31:0] ed, input logic [1:0] ei);
    vec_t t;
    t.valid = v; t.oready = r; t.data = d; t.rot = rt;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_id = ei;
    return t;
  endfunction

  vec_t tbl[17];
  int   lock_exp[6];
  logic [3:0][31:0] da, db, dc;
  logic [3:0][4:0]  ra, rb, rc;

  initial begin
    da = {32'h0000_1000, 32'h0000_0100, 32'h0000_0010, 32'h0000_0001};
    ra = {5'd31, 5'd8, 5'd4, 5'd1};
    db = {32'h0000_00A5, 32'h1111_1111, 32'hDEAD_BEEF, 32'h1234_5678};
    rb = {5'd0, 5'd0, 5'd0, 5'd16};
    dc = {32'h0, 32'h8000_0001, 32'h0, 32'h0};
    rc = {5'd0, 5'd1, 5'd0, 5'd0};

    tbl[0]  = mk(4'b0100, 1, dc, rc, 4'b0100, 1, 32'hC000_0000, 2);
    tbl[1]  = mk(4'b1111, 1, da, ra, 4'b1000, 1, 32'h0000_2000, 3);
    tbl[2]  = mk(4'b1111, 1, da, ra, 4'b0001, 1, 32'h8000_0000, 0);
    tbl[3]  = mk(4'b1111, 1, da, ra, 4'b0010, 1, 32'h0000_0001, 1);
    tbl[4]  = mk(4'b1111, 1, da, ra, 4'b0100, 1, 32'h0000_0001, 2);
    tbl[5]  = mk(4'b1111, 1, da, ra, 4'b1000, 1, 32'h0000_2000, 3);
    tbl[6]  = mk(4'b0000, 1, da, ra, 4'b0000, 0, 32'h0000_2000, 3);
    tbl[7]  = mk(4'b0010, 1, db, rb, 4'b0010, 1, 32'hDEAD_BEEF, 1);
    tbl[8]  = mk(4'b0011, 1, db, rb, 4'b0001, 1, 32'h5678_1234, 0);
    tbl[9]  = mk(4'b1111, 0, db, rb, 4'b0000, 1, 32'h5678_1234, 0);
    tbl[10] = mk(4'b1111, 0, db, rb, 4'b0000, 1, 32'h5678_1234, 0);
    tbl[11] = mk(4'b1111, 0, db, rb, 4'b0000, 1, 32'h5678_1234, 0);
    tbl[12] = mk(4'b1111, 1, db, rb, 4'b0010, 1, 32'hDEAD_BEEF, 1);
    tbl[13] = mk(4'b0000, 1, db, rb, 4'b0000, 0, 32'hDEAD_BEEF, 1);
    tbl[14] = mk(4'b1000, 0, db, rb, 4'b1000, 1, 32'h0000_00A5, 3);
    tbl[15] = mk(4'b1000, 0, db, rb, 4'b0000, 1, 32'h0000_00A5, 3);
    tbl[16] = mk(4'b1111, 1, db, rb, 4'b0001, 1, 32'h5678_1234, 0);

`ifdef ROTATOR_ARB_LOCK_EN
    lock_exp = '{0, 0, 0, 0, 1, 0};
`else
    lock_exp = '{0, 1, 0, 1, 0, 1};
`endif

    // Reset state, with requests pending
    req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[n]) begin
      req_valid = tbl[n].valid; out_ready = tbl[n].oready;
      req_data = tbl[n].data;   req_rot = tbl[n].rot;
      #1;
      chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(tbl[n].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", n), 32'(out_valid), 32'(tbl[n].exp_valid));
      chk($sformatf("v%0d_data", n), out_data, tbl[n].exp_data);
      chk($sformatf("v%0d_id", n), 32'(out_id), 32'(tbl[n].exp_id));
    end

    // Asynchronous reset mid-stream, then restart at requester 0
    req_valid = 4'b1111; out_ready = 1'b1; req_data = da; req_rot = ra;
    @(posedge clk); #2;
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk($sformatf("restart_id%0d", j), 32'(out_id), 32'(j % 4));
      chk($sformatf("restart_valid%0d", j), 32'(out_valid), 32'h1);
    end

    // Coarse rotate granularity on the second instance
    b_valid = 4'b0001; b_data[0] = 32'h1122_3344; b_rot[0] = 2'd3;
    @(posedge clk); #1;
    chk("b_rot3", b_out_data, 32'h2233_4411);
    chk("b_rot3_id", 32'(b_out_id), 32'h0);
    b_valid = 4'b0100; b_data[2] = 32'hCAFE_F00D; b_rot[2] = 2'd0;
    @(posedge clk); #1;
    chk("b_rot0", b_out_data, 32'hCAFE_F00D);
    chk("b_rot0_id", 32'(b_out_id), 32'h2);
    b_valid = 4'b0010; b_data[1] = 32'hAABB_CCDD; b_rot[1] = 2'd1;
    @(posedge clk); #1;
    chk("b_rot1", b_out_data, 32'hDDAA_BBCC);
    chk("b_rot1_id", 32'(b_out_id), 32'h1);
    b_valid = 4'b0000;

    // Burst lock from requester 0 against requester 1
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b0011; req_lock = 4'b0001; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      chk($sformatf("lock_id%0d", j), 32'(out_id), 32'(lock_exp[j]));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rotator_arbiter.md
# rotator_arbiter

Shares one right-rotate barrel datapath between `NUM_REQ` requesters. Each requester offers a data word and a rotation amount over a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the rotated result is captured in a single registered output stage that carries the requester's ID. The block sits between the producers of rotate operations and the shared rotator, so the rotator logic is instantiated only once.

## Interface
- `WIDTH`, default 32: data width in bits, for both input and output.
- `SHIFTBITS_PER_STEP`, default 1: bits moved per unit of rotation; `WIDTH/SHIFTBITS_PER_STEP` must be a power of two ≥ 2.
- `NUM_REQ`, default 4: number of requesters, ≥ 2.
- `MAX_BURST`, default 4: maximum consecutive locked grants (used only with the lock feature), ≥ 1.
- Derived: `ROTW = $clog2(WIDTH/SHIFTBITS_PER_STEP)`, `IDW = $clog2(NUM_REQ)`.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operation valid.
- `req_data`  in  NUM_REQ*WIDTH  flattened; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_rot`  in  NUM_REQ*ROTW  flattened rotate-right amount, in steps.
- `req_lock`  in  NUM_REQ  burst-lock request; ignored unless `ROTATOR_ARB_LOCK_EN` is defined.
- `req_ready`  out  NUM_REQ  one-hot or zero; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `out_valid`  out  1  the output register holds a result.
- `out_data`  out  WIDTH  the rotated word.
- `out_id`  out  IDW  index of the requester that produced `out_data`.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- `accept = !out_valid || out_ready`. Arbitration happens only when `accept` is high; otherwise all `req_ready` bits are 0.
- Grant selection: the first `i` with `req_valid[i]`, searching circularly from `rr_ptr`.
  - The search wraps from `NUM_REQ-1` to 0.
  - `req_ready` is combinational and depends on `req_valid` and `rr_ptr`, never on `req_data`.
- On a transfer from requester g:
  - `out_data <= rotr(req_data[g], req_rot[g]*SHIFTBITS_PER_STEP)`.
  - `out_id <= g`.
  - `out_valid <= 1`.
  - `rr_ptr <= (g+1) mod NUM_REQ`.
- When `accept` is high and no requester is valid, `out_valid <= 0`. `out_data` and `out_id` hold their values.
- A rotation of 0 passes the data through unchanged. Every `ROTW`-bit value is a legal rotation amount.
- Simultaneous pop and push (`out_valid && out_ready` with a new grant in the same cycle) replaces the register contents. There is no bubble.
- When `out_valid && !out_ready`, all registered output fields and `rr_ptr` are held stable.

## Timing
- Latency: a grant in cycle N gives `out_valid` and `out_data` in cycle N+1.
- Throughput: one operation per cycle while `out_ready` stays high.
- Reset values: `out_valid=0`, `out_data=0`, `out_id=0`, `rr_ptr=0`, `burst_cnt=0`, `last_id=0`, `locked=0`.
- `req_ready` is all-zero while `rst_n` is low.
- Reset asserted mid-operation discards any held result immediately (asynchronously). The first grant after release starts searching at requester 0.
- Fairness: without the lock feature, a continuously valid requester is granted within `NUM_REQ` accepting cycles.

## Configuration
- Macro: `ROTATOR_ARB_LOCK_EN`.
- Defined: lock feature compiled in.
  - If the previous grant went to g with `req_lock[g]=1`, g is still valid, and `burst_cnt < MAX_BURST-1`, then g is granted again ahead of the round-robin search.
  - `rr_ptr` is not advanced on a locked re-grant, and `burst_cnt` increments.
  - `burst_cnt` clears on any normal round-robin grant.
  - When `burst_cnt` reaches `MAX_BURST-1`, the lock is ignored for one arbitration, which uses normal round-robin.
  - The maximum run of consecutive grants to one locked requester is therefore `MAX_BURST`.
- Not defined: `req_lock` is ignored, and `burst_cnt`, `last_id` and `locked` are not synthesized. Behaviour is pure round-robin.

## Test plan
- Reset, then requester 2 alone with `req_data=32'h8000_0001`, `req_rot=1`, `out_ready=1`: `req_ready=4'b0100`, next cycle `out_data=32'hC000_0000` and `out_id=2`.
- All four requesters valid continuously with `out_ready=1`: `out_id` sequence 0,1,2,3,0 on consecutive cycles, one result per cycle.
- Hold `out_ready=0` for 3 cycles with `out_valid=1`: all `req_ready=0`, and `out_data`/`out_id` stay stable. Raising `out_ready` produces a new result the next cycle with no gap.
- Assert `rst_n=0` mid-stream with `out_valid=1`: `out_valid=0` immediately. After release with all requesters valid, the first `out_id` is 0.
- `SHIFTBITS_PER_STEP=8`, `req_rot=3`, `req_data=32'h1122_3344`: `out_data=32'h2233_4411`. `req_rot=0` returns the input unchanged.
- With `ROTATOR_ARB_LOCK_EN`, `MAX_BURST=4`, requesters 0 and 1 valid, `req_lock[0]=1`: `out_id` sequence 0,0,0,0,1,0,…. Without the macro, the sequence is 0,1,0,1.
